egr_tqu_prc_req: RTL

EGR_TQU_PRC_REQ -- requirements
Module: egr_tqu_prc_req

---
 rtl/egr_tqu_prc_req.sv | 131 +++++++++++++
 1 files changed

// File: rtl/egr_tqu_prc_req.sv
// Egress TQU -> PRC read-request issuer: descriptor FIFO, credit-limited output register.
// Optional parity carry/check is enabled with `define EGR_TQU_PRC_PARITY_EN.
module egr_tqu_prc_req #(
    parameter int DEPTH   = 8,
    parameter int CREDITS = 4,
    parameter int PTR_W   = 12,
    parameter int PORT_W  = 5,
    parameter int LEN_W   = 14
) (
    input  logic                       cclk,
    input  logic                       rst,
    input  logic                       sch_valid,
    output logic                       sch_ready,
    input  logic [PORT_W-1:0]          sch_port,
    input  logic [PTR_W-1:0]           sch_ptr,
    input  logic [LEN_W-1:0]           sch_len,
`ifdef EGR_TQU_PRC_PARITY_EN
    input  logic                       sch_par,
    output logic                       prc_req_par,
    output logic                       err_par,
`endif
    output logic                       prc_req_valid,
    input  logic                       prc_req_ready,
    output logic [PORT_W-1:0]          prc_req_port,
    output logic [PTR_W-1:0]           prc_req_ptr,
    output logic [LEN_W-1:0]           prc_req_len,
    input  logic                       prc_done,
    input  logic                       cfg_enable,
    output logic [$clog2(DEPTH):0]     fifo_cnt,
    output logic [$clog2(CREDITS):0]   credit_cnt,
    output logic                       idle,
    output logic                       err_credit_ovf
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int OW = $clog2(CREDITS) + 1;

    typedef struct packed {
        logic [PORT_W-1:0] port;
        logic [PTR_W-1:0]  ptr;
        logic [LEN_W-1:0]  len;
`ifdef EGR_TQU_PRC_PARITY_EN
        logic              par;
`endif
    } desc_t;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_CRED} state_t;

    desc_t          mem [DEPTH];
    desc_t          din, head, req_q;
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  cnt, cnt_nxt;
    logic [OW-1:0]  outst, outst_nxt;
    logic           push, load, dec, vld_nxt;
    state_t         state;

    assign din.port = sch_port;
    assign din.ptr  = sch_ptr;
    assign din.len  = sch_len;
`ifdef EGR_TQU_PRC_PARITY_EN
    assign din.par  = sch_par;
`endif

    // Ready comes from the registered count only: a full FIFO refuses even while popping.
    assign sch_ready = !rst && (cnt < CW'(DEPTH));
    assign push      = sch_valid && sch_ready;
    assign load      = (!prc_req_valid || prc_req_ready) && (cnt != '0) &&
                       (outst < OW'(CREDITS)) && cfg_enable;
    // A done arriving with nothing outstanding is an error and never underflows.
    assign dec       = prc_done && (outst != '0);
    assign head      = mem[rd_ptr];
    assign vld_nxt   = load || (prc_req_valid && !prc_req_ready);
    assign cnt_nxt   = cnt + CW'(push) - CW'(load);
    assign outst_nxt = outst + OW'(load) - OW'(dec);

    always_ff @(posedge cclk) begin
        if (push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge cclk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            cnt            <= '0;
            outst          <= '0;
            req_q          <= '0;
            prc_req_valid  <= 1'b0;
            err_credit_ovf <= 1'b0;
            state          <= IDLE;
`ifdef EGR_TQU_PRC_PARITY_EN
            err_par        <= 1'b0;
`endif
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (load) begin
                rd_ptr <= rd_ptr + AW'(1);
                req_q  <= head;
            end
            cnt           <= cnt_nxt;
            outst         <= outst_nxt;
            prc_req_valid <= vld_nxt;
            if (prc_done && (outst == '0)) err_credit_ovf <= 1'b1;
`ifdef EGR_TQU_PRC_PARITY_EN
            // Even parity: the xor over fields plus parity bit must be zero.
            if (push && (^din)) err_par <= 1'b1;
`endif
            case (state)
                IDLE, WAIT_CRED, ISSUE: begin
                    if (vld_nxt)
                        state <= ISSUE;
                    else if ((cnt_nxt != '0) && !(cfg_enable && (outst_nxt < OW'(CREDITS))))
                        state <= WAIT_CRED;
                    else
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign prc_req_port = req_q.port;
    assign prc_req_ptr  = req_q.ptr;
    assign prc_req_len  = req_q.len;
`ifdef EGR_TQU_PRC_PARITY_EN
    assign prc_req_par  = req_q.par;
`endif
    assign fifo_cnt     = cnt;
    assign credit_cnt   = OW'(CREDITS) - outst;
    assign idle         = (state == IDLE) && (cnt == '0) && !prc_req_valid && (outst == '0);

endmodule
